// File: rtl/psx_mem_pkg.sv
// Shared types and constants for the memory request arbiter and the address interpreter path.
package psx_mem_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} arb_state_t;
  typedef enum logic {REQ_IF, REQ_DM} req_id_t;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; IF wins the first tie after reset.
module rr_arb2
  import psx_mem_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    req_if,
  input  logic    req_dm,
  input  logic    update_en,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  req_id_t last_grant_q, last_grant_d;

  always_comb begin
    gnt_valid = req_if | req_dm;
    if (req_if && req_dm) begin
      gnt_id = (last_grant_q == REQ_DM) ? REQ_IF : REQ_DM;
    end else if (req_if) begin
      gnt_id = REQ_IF;
    end else begin
      gnt_id = REQ_DM;
    end
    last_grant_d = last_grant_q;
    if (update_en && gnt_valid) begin
      last_grant_d = gnt_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_DM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates IF and DM requests onto the interpreter's ren/wen/ack handshake,
// with a watchdog that aborts unanswered accesses with an error completion.
module mem_req_arbiter
  import psx_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_wen,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_done,
  output logic        dm_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_i,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic        mem_ack,
  input  logic [31:0] mem_data_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  arb_state_t      state_q, state_d;
  req_id_t         gnt_id_q, gnt_id_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     mem_addr_q, mem_addr_d, mem_data_i_q, mem_data_i_d;
  logic            mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
  logic [31:0]     if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic            if_done_q, if_done_d, if_err_q, if_err_d;
  logic            dm_done_q, dm_done_d, dm_err_q, dm_err_d;

  logic    arb_update, arb_valid, is_write;
  req_id_t arb_id;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req_if    (if_req),
    .req_dm    (dm_req),
    .update_en (arb_update),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  always_comb begin
    state_d      = state_q;
    gnt_id_d     = gnt_id_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_data_i_d = mem_data_i_q;
    mem_ren_d    = mem_ren_q;
    mem_wen_d    = mem_wen_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    if_done_d    = 1'b0;
    if_err_d     = 1'b0;
    dm_done_d    = 1'b0;
    dm_err_d     = 1'b0;
    arb_update   = 1'b0;
    is_write     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          arb_update   = 1'b1;
          is_write     = (arb_id == REQ_DM) && dm_wen;
          gnt_id_d     = arb_id;
          mem_addr_d   = (arb_id == REQ_DM) ? dm_addr : if_addr;
          mem_data_i_d = (arb_id == REQ_DM) ? dm_wdata : 32'h0;
          mem_ren_d    = ~is_write;
          mem_wen_d    = is_write;
          cnt_d        = '0;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        // Ack has priority over an expiring watchdog in the same cycle.
        if (mem_ack || (cnt_q == CntLast)) begin
          mem_ren_d = 1'b0;
          mem_wen_d = 1'b0;
          state_d   = RELEASE;
          if (gnt_id_q == REQ_IF) begin
            if_done_d = 1'b1;
            if_err_d  = ~mem_ack;
            if (mem_ren_q) if_rdata_d = mem_ack ? mem_data_o : ERR_RDATA;
          end else begin
            dm_done_d = 1'b1;
            dm_err_d  = ~mem_ack;
            if (mem_ren_q) dm_rdata_d = mem_ack ? mem_data_o : ERR_RDATA;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!mem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_id_q     <= REQ_IF;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_data_i_q <= '0;
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
      if_done_q    <= 1'b0;
      if_err_q     <= 1'b0;
      dm_done_q    <= 1'b0;
      dm_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_id_q     <= gnt_id_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_i_q <= mem_data_i_d;
      mem_ren_q    <= mem_ren_d;
      mem_wen_q    <= mem_wen_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
      if_done_q    <= if_done_d;
      if_err_q     <= if_err_d;
      dm_done_q    <= dm_done_d;
      dm_err_q     <= dm_err_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_data_i = mem_data_i_q;
  assign mem_ren    = mem_ren_q;
  assign mem_wen    = mem_wen_q;
  assign if_rdata   = if_rdata_q;
  assign if_done    = if_done_q;
  assign if_err     = if_err_q;
  assign dm_rdata   = dm_rdata_q;
  assign dm_done    = dm_done_q;
  assign dm_err     = dm_err_q;

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits directly upstream of the address interpreter.
- Arbitrates between the CPU instruction-fetch port (IF) and the data-memory port (DM). Drives the interpreter's single ren/wen/ack four-phase handshake and returns read data or a completion pulse to the winning requester.
- Adds a watchdog timeout so that an unmapped or unanswered access cannot hang the CPU.

Parameters:
TIMEOUT_CYCLES, 1024, cycles mem_ack may stay low in ISSUE before the access is aborted with an error.
ERR_RDATA, 32'hFFFF_FFFF, read data returned on a timed-out access.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  reset; synchronous, active-high.
if_req  in  1  fetch request (read-only); held with if_addr until if_done.
if_addr  in  32  fetch address.
if_rdata  out  32  fetch read data; valid in the if_done cycle and held until the next IF completion.
if_done  out  1  one-cycle completion pulse for IF.
if_err  out  1  high together with if_done when the access timed out.
dm_req  in  1  data request; held with dm_wen, dm_addr and dm_wdata until dm_done.
dm_wen  in  1  1 = write, 0 = read.
dm_addr  in  32  data address.
dm_wdata  in  32  write data.
dm_rdata  out  32  data read data; valid in the dm_done cycle and held until the next DM completion.
dm_done  out  1  one-cycle completion pulse for DM.
dm_err  out  1  high together with dm_done when the access timed out.
mem_addr  out  32  address to the interpreter.
mem_data_i  out  32  write data to the interpreter.
mem_ren  out  1  read strobe, level held until ack.
mem_wen  out  1  write strobe, level held until ack.
mem_ack  in  1  interpreter acknowledge.
mem_data_o  in  32  interpreter read data; valid only on the first cycle mem_ack is high.

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge) applies from any state, including mid-access:
  - state=IDLE; all outputs are 0.
  - last_grant=DM, so IF wins the first tie.
  - timeout counter=0.
  - A downstream access in flight is dropped; the interpreter recovers by seeing ren/wen low.
- States: IDLE, ISSUE, RELEASE.
- IDLE:
  - If no request is pending, stay.
  - If exactly one of if_req/dm_req is set, grant it.
  - If both are set, grant the one that is not last_grant (round-robin), then update last_grant.
  - On grant, the next edge loads mem_addr, mem_data_i (=dm_wdata for DM, else 0), mem_ren=~wen and mem_wen=wen (IF is always a read), latches the granted id, clears the counter, and goes to ISSUE.
- ISSUE:
  - mem_addr, mem_data_i, mem_ren and mem_wen are held stable; requester inputs are ignored.
  - On mem_ack=1:
    - capture mem_data_o into the granted rdata register (reads only; writes leave rdata unchanged);
    - pulse the granted done for one cycle with err=0;
    - drop mem_ren and mem_wen;
    - go to RELEASE.
  - Otherwise, if counter==TIMEOUT_CYCLES-1:
    - drop the strobes;
    - pulse done with err=1; rdata=ERR_RDATA for reads (writes leave rdata unchanged);
    - go to RELEASE.
  - Otherwise, increment the counter.
  - If mem_ack=1 arrives in the same cycle the timeout expires, the ack wins and err=0.
- RELEASE:
  - Strobes stay low. When mem_ack=0, go to IDLE on the next edge.
  - A request is not sampled before IDLE; a requester re-asserting the cycle after done simply waits.
- Latency: request seen in IDLE at cycle N -> strobe high at N+1. Ack seen at cycle A -> done and strobe low at A+1. Ack low seen at cycle B -> IDLE at B+1.
- Counter width is $clog2(TIMEOUT_CYCLES)+1 and it saturates; it never wraps.
- done is never asserted for both ports in the same cycle.
- A write is complete at done; no read data is returned for it.

Decomposition:
- Shared package psx_mem_pkg:
  - arb_state_t enum {IDLE, ISSUE, RELEASE};
  - req_id_t enum {REQ_IF, REQ_DM};
  - ERR_RDATA default constant.
- One sub-module, rr_arb2: a two-input round-robin grant with a last_grant register, update enable, and sync reset. The FSM, timeout counter and datapath registers stay in mem_req_arbiter.

Test Plan:
- IF read 0xBFC0_0000; model acks 3 cycles after ren with data 0x3C08_0013 -> mem_ren high 1 cycle after req; if_rdata=0x3C08_0013 with if_done for 1 cycle, if_err=0; mem_ren low in the done cycle.
- DM write addr 0x1F80_0010, data 0xDEAD_BEEF -> mem_wen=1, mem_ren=0, mem_data_i=0xDEAD_BEEF stable until ack; dm_done=1 one cycle; dm_rdata unchanged.
- if_req and dm_req both high from reset, each re-asserted after done -> grant order IF, DM, IF, DM; no overlapping strobes; the next strobe only rises after ack returns low.
- Model never acks (TIMEOUT_CYCLES=8), DM read -> dm_done with dm_err=1 exactly 8 cycles after mem_ren rose; dm_rdata=0xFFFF_FFFF; strobe low; state back in IDLE.
- Ack arrives on the timeout-expiry cycle -> err=0 and data captured from mem_data_o.
- rst asserted while in ISSUE with mem_ren=1 -> next edge: all outputs 0, state IDLE; a subsequent pending if_req and dm_req is granted to IF.
